// File: rtl/clk_en_seq.sv
// Purpose : clock-enable sequencer for one AND-gated clock island; gates after a run of idle cycles, wakes on request.
// Latency : thr=N with wake low from cycle 0 -> state OFF at posedge N+1, o_en low at the next negedge; wake at k -> o_en high at negedge k.
// Backpr. : none; wake is level-sensitive, always honoured in OFF, ignored during the fixed-length WAKE sequence.
//
// Ports:
//   i_clk           source clock, also clocks the downstream AND gate
//   i_rst_n         asynchronous active-low reset (posedge and negedge flops)
//   i_cfg_idle_thr  consecutive idle cycles before gating; 0 disables auto-gating
//   i_busy          island activity (high = not idle)
//   i_req           level-sensitive wake / keep-alive request
//   i_force_on      software override, holds the clock on
//   o_en            gate enable, retimed on the falling edge so the AND gate never glitches
//   o_ack           island clock running and stable (RUN or COUNT), registered
//   o_gated         high while OFF, registered
// Optional feature macro: CLK_EN_SEQ_DFT_BYPASS_EN adds i_test_en, which forces o_en/o_ack high
// combinationally and holds the FSM in RUN (static scan / test only).
module clk_en_seq #(
   parameter int unsigned IDLE_W   = 8,
   parameter int unsigned WAKE_CYC = 2
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [IDLE_W-1:0] i_cfg_idle_thr,
   input  logic              i_busy,
   input  logic              i_req,
   input  logic              i_force_on,
`ifdef CLK_EN_SEQ_DFT_BYPASS_EN
   input  logic              i_test_en,
`endif
   output logic              o_en,
   output logic              o_ack,
   output logic              o_gated
);

   // Wake counter must hold WAKE_CYC-1; keep at least one bit when WAKE_CYC is 1.
   localparam int unsigned WC_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;
   localparam logic [WC_W-1:0] WC_INIT = WC_W'(WAKE_CYC - 1);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_COUNT = 2'd1,
      ST_OFF   = 2'd2,
      ST_WAKE  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [WC_W-1:0]   wake_cnt_q, wake_cnt_d;
   logic              ack_q;
   logic              gated_q;
   logic              en_q;

   logic wake;
   logic thr_nz;
   logic en_req;

   assign wake   = i_busy | i_req | i_force_on;
   assign thr_nz = |i_cfg_idle_thr;
   assign en_req = (state_q != ST_OFF);

   // Next-state logic; the threshold is compared live every cycle.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      unique case (state_q)
         ST_RUN: begin
            idle_cnt_d = '0;
            if (!wake && thr_nz) begin
               state_d    = ST_COUNT;
               idle_cnt_d = IDLE_W'(1);
            end
         end
         ST_COUNT: begin
            // Wake beats a coincident threshold hit. A threshold lowered to 0
            // mid-count satisfies the >= test first, so that island still gates.
            if (wake) begin
               state_d    = ST_RUN;
               idle_cnt_d = '0;
            end else if (idle_cnt_q >= i_cfg_idle_thr) begin
               state_d    = ST_OFF;
               idle_cnt_d = '0;
            end else if (!thr_nz) begin
               state_d    = ST_RUN;
               idle_cnt_d = '0;
            end else if (idle_cnt_q != '1) begin
               idle_cnt_d = idle_cnt_q + IDLE_W'(1);
            end
         end
         ST_OFF: begin
            if (wake) begin
               state_d    = ST_WAKE;
               wake_cnt_d = WC_INIT;
            end
         end
         ST_WAKE: begin
            // Fixed-length settle; wake has no effect until it completes.
            if (wake_cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               wake_cnt_d = wake_cnt_q - WC_W'(1);
            end
         end
         default: begin
            state_d    = ST_RUN;
            idle_cnt_d = '0;
            wake_cnt_d = '0;
         end
      endcase
`ifdef CLK_EN_SEQ_DFT_BYPASS_EN
      if (i_test_en) begin
         state_d    = ST_RUN;
         idle_cnt_d = '0;
         wake_cnt_d = '0;
      end
`endif
   end

   // State, counters and status flags; status is registered from the current
   // state, so it trails the state by one cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_RUN;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
         ack_q      <= 1'b1;
         gated_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
         ack_q      <= (state_q == ST_RUN) || (state_q == ST_COUNT);
         gated_q    <= (state_q == ST_OFF);
      end
   end

   // Falling-edge retime: the enable only moves while i_clk is low.
   always_ff @(negedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         en_q <= 1'b1;
      end else begin
         en_q <= en_req;
      end
   end

`ifdef CLK_EN_SEQ_DFT_BYPASS_EN
   assign o_en  = en_q | i_test_en;
   assign o_ack = ack_q | i_test_en;
`else
   assign o_en  = en_q;
   assign o_ack = ack_q;
`endif
   assign o_gated = gated_q;

endmodule

// File: tb/tb_clk_en_seq.sv
module tb_clk_en_seq;

   localparam int IDLE_W   = 8;
   localparam int WAKE_CYC = 2;

   logic              i_clk   = 1'b0;
   logic              i_rst_n = 1'b1;
   logic [IDLE_W-1:0] thr     = '0;
   logic              busy    = 1'b0;
   logic              req     = 1'b0;
   logic              frc     = 1'b0;
   logic              test_en = 1'b0;
   logic              o_en;
   logic              o_ack;
   logic              o_gated;

   int checks   = 0;
   int failures = 0;

   clk_en_seq #(.IDLE_W(IDLE_W), .WAKE_CYC(WAKE_CYC)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_cfg_idle_thr (thr),
      .i_busy         (busy),
      .i_req          (req),
      .i_force_on     (frc),
`ifdef CLK_EN_SEQ_DFT_BYPASS_EN
      .i_test_en      (test_en),
`endif
      .o_en           (o_en),
      .o_ack          (o_ack),
      .o_gated        (o_gated)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: the island is running, off, or waking until a known
   // cycle number; idle cycles are counted as a plain integer run length.
   bit m_off    = 1'b0;
   bit m_waking = 1'b0;
   int m_idle   = 0;
   int m_cyc    = 0;
   int m_resume = 0;
   bit m_ack    = 1'b1;
   bit m_gated  = 1'b0;
   bit m_w;

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         m_off = 0; m_waking = 0; m_idle = 0; m_cyc = 0; m_resume = 0;
         m_ack = 1; m_gated = 0;
      end else begin
         m_w     = busy | req | frc;
         m_ack   = !m_off && !m_waking;
         m_gated = m_off;
         m_cyc++;
`ifdef CLK_EN_SEQ_DFT_BYPASS_EN
         if (test_en) begin
            m_off = 0; m_waking = 0; m_idle = 0;
         end else
`endif
         if (m_waking) begin
            if (m_cyc >= m_resume) m_waking = 0;
         end else if (m_off) begin
            if (m_w) begin
               m_off = 0; m_waking = 1; m_resume = m_cyc + WAKE_CYC;
            end
         end else if (m_w) begin
            m_idle = 0;
         end else if (m_idle == 0) begin
            m_idle = (thr != 0) ? 1 : 0;
         end else if (m_idle >= int'(thr)) begin
            m_off = 1; m_idle = 0;
         end else begin
            m_idle++;
         end
      end
   end

   // Per-cycle compare, just after the falling edge that retimes o_en.
   always @(negedge i_clk) begin
      #1;
      check("cyc_en",    {31'b0, o_en},    {31'b0, (!m_off) | test_en});
      check("cyc_ack",   {31'b0, o_ack},   {31'b0, m_ack | test_en});
      check("cyc_gated", {31'b0, o_gated}, {31'b0, m_gated});
   end

   // Glitch monitor: outside of reset, o_en may only move while i_clk is low.
   always @(o_en) begin
      if (i_rst_n === 1'b1) check("glitch_clk_at_en_change", {31'b0, i_clk}, 32'd0);
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge i_clk);
      @(negedge i_clk);
      #2;
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      step();
      step();
      i_rst_n = 1'b1;
   endtask

   initial begin
      #1;
      @(negedge i_clk);
      #2;

      // Reset then idle, thr=4: OFF at posedge 5, o_gated one cycle later.
      thr = 8'd4; busy = 0; req = 0; frc = 0;
      do_reset();
      check("rst_en",    {31'b0, o_en},    32'd1);
      check("rst_ack",   {31'b0, o_ack},   32'd1);
      check("rst_gated", {31'b0, o_gated}, 32'd0);
      for (int p = 1; p <= 6; p++) begin
         step();
         if (p == 4) check("idle_en_p4", {31'b0, o_en}, 32'd1);
         if (p == 5) begin
            check("idle_en_p5",    {31'b0, o_en},    32'd0);
            check("idle_gated_p5", {31'b0, o_gated}, 32'd0);
         end
         if (p == 6) begin
            check("idle_gated_p6", {31'b0, o_gated}, 32'd1);
            check("idle_ack_p6",   {31'b0, o_ack},   32'd0);
         end
      end

      // Wake from OFF with a one-cycle request pulse.
      step(); step();
      req = 1;
      step();
      check("wake_en_k", {31'b0, o_en}, 32'd1);
      req = 0; busy = 1;
      step();
      check("wake_ack_k1",   {31'b0, o_ack},   32'd0);
      check("wake_gated_k1", {31'b0, o_gated}, 32'd0);
      step();
      check("wake_ack_k2", {31'b0, o_ack}, 32'd0);
      step();
      check("wake_ack_k3", {31'b0, o_ack}, 32'd1);

      // Collision: busy returns on the cycle the count would hit thr=3.
      thr = 8'd3; busy = 0;
      do_reset();
      step(); step(); step();
      busy = 1;
      step();
      check("coll_en",  {31'b0, o_en},  32'd1);
      check("coll_ack", {31'b0, o_ack}, 32'd1);
      busy = 0;
      for (int p = 5; p <= 8; p++) begin
         step();
         if (p == 7) check("coll_recount_en_p7", {31'b0, o_en}, 32'd1);
         if (p == 8) check("coll_recount_en_p8", {31'b0, o_en}, 32'd0);
      end

      // Threshold lowered mid-count takes effect on the next cycle.
      thr = 8'd6;
      do_reset();
      step(); step(); step();
      thr = 8'd2;
      step();
      check("live_thr_en", {31'b0, o_en}, 32'd0);

      // thr=0 disables gating entirely.
      thr = 8'd0; busy = 0;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step();
         check("thr0_en", {31'b0, o_en}, 32'd1);
      end

      // Async reset in OFF while i_clk is high.
      thr = 8'd1;
      step(); step(); step();
      check("pre_rst_off_en", {31'b0, o_en}, 32'd0);
      @(posedge i_clk);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("async_rst_en",    {31'b0, o_en},    32'd1);
      check("async_rst_ack",   {31'b0, o_ack},   32'd1);
      check("async_rst_gated", {31'b0, o_gated}, 32'd0);
      @(negedge i_clk);
      #2;
      busy = 1;
      i_rst_n = 1'b1;
      step();
      check("post_rst_ack",   {31'b0, o_ack},   32'd1);
      check("post_rst_en",    {31'b0, o_en},    32'd1);
      check("post_rst_gated", {31'b0, o_gated}, 32'd0);

      // Mixed traffic, checked by the model every cycle.
      for (int i = 0; i < 240; i++) begin
         thr  = IDLE_W'(1 + (i / 60) * 2);
         busy = ((i % 17) < 2);
         req  = ((i % 23) == 5);
         frc  = ((i % 53) >= 40) && ((i % 53) < 44);
         step();
      end
      busy = 0; req = 0; frc = 0;

`ifdef CLK_EN_SEQ_DFT_BYPASS_EN
      thr = 8'd2;
      do_reset();
      step(); step(); step();
      check("dft_pre_en", {31'b0, o_en}, 32'd0);
      test_en = 1;
      #1;
      check("dft_en",  {31'b0, o_en},  32'd1);
      check("dft_ack", {31'b0, o_ack}, 32'd1);
      step(); step();
      test_en = 0;
      step(); step();
      check("dft_rel_en_p2", {31'b0, o_en}, 32'd1);
      step();
      check("dft_rel_en_p3", {31'b0, o_en}, 32'd0);
`endif

      step(); step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
